// File: rtl/mfp_ahb_7seg_scanner.sv
// mfp_ahb_7seg_scanner
//   AHB-Lite slave that drives an N-digit multiplexed seven-segment display.
//   It has an integrated scan engine, per-digit blink, global PWM brightness,
//   a global blank control and readback of every register.
//
// Ports
//   HCLK, HRESETn      clock, asynchronous active-low reset
//   HSEL, HADDR[3:0]   slave select, word index (bus address bits 5:2)
//   HTRANS[1:0]        transfer type; bit 1 marks a valid transfer
//   HWRITE, HWDATA     write strobe and write data (data phase)
//   HRDATA             read data (data phase, combinational)
//   HREADYOUT          always 1
//   IO_7SEGEN_N        digit anodes, active low
//   IO_7SEG_N[6:0]     segments a..g on bits 0..6, active low
//   IO_7SEG_DP         decimal point, active low
//
// Register map (word index)
//   0 EN     [N-1:0] 1 = digit off        3 DIGLO  nibbles, digits 7..0
//   1 DP     [N-1:0] 1 = DP off           4 CTRL   [2:0] bright [3] blink en [4] blank
//   2 DIGHI  nibbles, digits 15..8        5 BLINK  [N-1:0] per-digit blink mask
module mfp_ahb_7seg_scanner #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_W     = 14,
  parameter int BLINK_W    = 25
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [3:0]            HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic [NUM_DIGITS-1:0] IO_7SEGEN_N,
  output logic [6:0]            IO_7SEG_N,
  output logic                  IO_7SEG_DP
);

  localparam int DSEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DSEL_W-1:0] DSEL_LAST = DSEL_W'(NUM_DIGITS - 1);

  // Active-low hex glyphs, segment a on bit 0.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  logic [3:0]            addr_p1;
  logic                  wr_p1;
  logic                  vld_p1;

  logic [NUM_DIGITS-1:0] en_reg;
  logic [NUM_DIGITS-1:0] dp_reg;
  logic [31:0]           dighi_reg;
  logic [31:0]           diglo_reg;
  logic [4:0]            ctrl_reg;
  logic [NUM_DIGITS-1:0] blink_reg;

  logic [SCAN_W-1:0]     scnt;
  logic [DSEL_W-1:0]     dsel;
  logic [BLINK_W-1:0]    bcnt;

  logic [31:0]           rd_word;
  logic [63:0]           digits;
  logic [5:0]            nib_lsb;
  logic [3:0]            nib;
  logic                  digit_on;
  logic                  unused_trans;

  assign HREADYOUT    = 1'b1;
  assign unused_trans = HTRANS[0];

  // Stage p1: AHB address phase capture. A transfer pending here is dropped
  // by reset because vld_p1 clears asynchronously.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vld_p1  <= 1'b0;
      wr_p1   <= 1'b0;
      addr_p1 <= '0;
    end else begin
      vld_p1  <= HSEL & HTRANS[1];
      wr_p1   <= HWRITE;
      addr_p1 <= HADDR;
    end
  end

  // Data phase: register writes. DIGHI is kept at full width whatever
  // NUM_DIGITS is, so software sees a uniform map.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en_reg    <= '1;
      dp_reg    <= '1;
      dighi_reg <= '0;
      diglo_reg <= '0;
      ctrl_reg  <= 5'h07;
      blink_reg <= '0;
    end else if (vld_p1 && wr_p1) begin
      case (addr_p1)
        4'd0: en_reg    <= HWDATA[NUM_DIGITS-1:0];
        4'd1: dp_reg    <= HWDATA[NUM_DIGITS-1:0];
        4'd2: dighi_reg <= HWDATA;
        4'd3: diglo_reg <= HWDATA;
        4'd4: ctrl_reg  <= HWDATA[4:0];
        4'd5: blink_reg <= HWDATA[NUM_DIGITS-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_word = '0;
    case (addr_p1)
      4'd0: rd_word = 32'(en_reg);
      4'd1: rd_word = 32'(dp_reg);
      4'd2: rd_word = dighi_reg;
      4'd3: rd_word = diglo_reg;
      4'd4: rd_word = 32'(ctrl_reg);
      4'd5: rd_word = 32'(blink_reg);
      default: rd_word = '0;
    endcase
  end

  assign HRDATA = (vld_p1 && !wr_p1) ? rd_word : 32'h0;

  // Scan engine: slot counter, digit select and free-running blink counter.
  // All start together from reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      scnt <= '0;
      dsel <= '0;
      bcnt <= '0;
    end else begin
      scnt <= scnt + 1'b1;
      bcnt <= bcnt + 1'b1;
      if (&scnt) begin
        dsel <= (dsel == DSEL_LAST) ? '0 : dsel + 1'b1;
      end
    end
  end

  assign digits  = {dighi_reg, diglo_reg};
  assign nib_lsb = {4'(dsel), 2'b00};
  assign nib     = digits[nib_lsb +: 4];

  // The top three slot-counter bits form the PWM ramp. At brightness 7 the
  // digit stays lit for the whole slot; at 0 it is lit for the first eighth.
  assign digit_on = !en_reg[dsel]
                  && !ctrl_reg[4]
                  && (scnt[SCAN_W-1 -: 3] <= ctrl_reg[2:0])
                  && !(ctrl_reg[3] && blink_reg[dsel] && bcnt[BLINK_W-1]);

  // Stage p2: registered pin drivers. An unlit digit forces segments and DP
  // off as well as the anode, so nothing ghosts onto the next digit.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      IO_7SEGEN_N <= '1;
      IO_7SEG_N   <= 7'h7F;
      IO_7SEG_DP  <= 1'b1;
    end else if (digit_on) begin
      IO_7SEGEN_N <= ~(NUM_DIGITS'(1) << dsel);
      IO_7SEG_N   <= hex_glyph(nib);
      IO_7SEG_DP  <= dp_reg[dsel];
    end else begin
      IO_7SEGEN_N <= '1;
      IO_7SEG_N   <= 7'h7F;
      IO_7SEG_DP  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mfp_ahb_7seg_scanner.sv
// Testbench for mfp_ahb_7seg_scanner: one 8-digit instance and one 6-digit
// instance (SCAN_W=4, BLINK_W=6) sharing clock, reset and bus wires, with
// separate slave selects.
module tb_mfp_ahb_7seg_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel8 = 1'b0;
  logic        sel6 = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [1:0]  trans = 2'b00;
  logic        write = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata8, rdata6;
  logic        rdy8, rdy6;
  logic [7:0]  en8;
  logic [5:0]  en6;
  logic [6:0]  seg8, seg6;
  logic        dp8, dp6;

  int checks = 0;
  int errors = 0;

  logic [6:0] glyph [0:7] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

  always #5 clk = ~clk;

  mfp_ahb_7seg_scanner #(.NUM_DIGITS(8), .SCAN_W(4), .BLINK_W(6)) dut8 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel8), .HADDR(addr), .HTRANS(trans),
    .HWRITE(write), .HWDATA(wdata), .HRDATA(rdata8), .HREADYOUT(rdy8),
    .IO_7SEGEN_N(en8), .IO_7SEG_N(seg8), .IO_7SEG_DP(dp8)
  );

  mfp_ahb_7seg_scanner #(.NUM_DIGITS(6), .SCAN_W(4), .BLINK_W(6)) dut6 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel6), .HADDR(addr), .HTRANS(trans),
    .HWRITE(write), .HWDATA(wdata), .HRDATA(rdata6), .HREADYOUT(rdy6),
    .IO_7SEGEN_N(en6), .IO_7SEG_N(seg6), .IO_7SEG_DP(dp6)
  );

  task automatic bus_write(input bit which, input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    sel8 = !which; sel6 = which; trans = 2'b10; write = 1'b1; addr = idx;
    @(negedge clk);
    sel8 = 1'b0; sel6 = 1'b0; trans = 2'b00; write = 1'b0; wdata = data;
    @(negedge clk);
  endtask

  task automatic bus_read(input bit which, input logic [3:0] idx, output logic [31:0] data);
    @(negedge clk);
    sel8 = !which; sel6 = which; trans = 2'b10; write = 1'b0; addr = idx;
    @(negedge clk);
    sel8 = 1'b0; sel6 = 1'b0; trans = 2'b00;
    data = which ? rdata6 : rdata8;
  endtask

  // Count, over one full 128-cycle scan period, how many cycles each anode of
  // the 8-digit instance is low, and how many unlit cycles show stray segments.
  task automatic count_period(output int lit [0:7], output int stray);
    stray = 0;
    for (int d = 0; d < 8; d++) lit[d] = 0;
    for (int c = 0; c < 128; c++) begin
      @(negedge clk);
      for (int d = 0; d < 8; d++) if (en8[d] === 1'b0) lit[d]++;
      if (en8 === 8'hFF && (seg8 !== 7'h7F || dp8 !== 1'b1)) stray++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    logic [31:0] exp_rd [0:5] = '{32'hFF, 32'hFF, 32'h0, 32'h0, 32'h7, 32'h0};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (en8 !== 8'hFF || seg8 !== 7'h7F || dp8 !== 1'b1 || rdata8 !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: en=%h seg=%h dp=%b rd=%h, want en=ff seg=7f dp=1 rd=0",
               en8, seg8, dp8, rdata8);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus_read(0, 4'(i), r);
      checks++;
      if (r !== exp_rd[i]) begin
        errors++;
        $display("FAIL reset_read idx %0d: got %h, want %h", i, r, exp_rd[i]);
      end
    end
  endtask

  task automatic test_scan();
    int n;
    int bad;
    logic [7:0] exp_en;
    logic       exp_dp;
    logic [7:0] bad_en;
    logic [6:0] bad_seg;
    bus_write(0, 4'd3, 32'h76543210);
    bus_write(0, 4'd0, 32'h0);
    bus_write(0, 4'd1, 32'hFE);
    n = 0;
    while (en8 !== 8'h7F && n < 400) begin @(negedge clk); n++; end
    while (en8 === 8'h7F && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL scan_align: en=%h after %0d cycles, want slot edge 7f->fe", en8, n);
      return;
    end
    // Nine slots: digits 0..7 then the wrap back to digit 0.
    for (int s = 0; s < 9; s++) begin
      exp_en = ~(8'h01 << (s % 8));
      exp_dp = ((s % 8) == 0) ? 1'b0 : 1'b1;
      bad = 0; bad_en = 8'h0; bad_seg = 7'h0;
      for (int c = 0; c < 16; c++) begin
        if (en8 !== exp_en || seg8 !== glyph[s % 8] || dp8 !== exp_dp) begin
          bad++; bad_en = en8; bad_seg = seg8;
        end
        @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL scan_slot %0d: %0d bad cycles, e.g. en=%h seg=%h, want en=%h seg=%h dp=%b",
                 s, bad, bad_en, bad_seg, exp_en, glyph[s % 8], exp_dp);
      end
    end
  endtask

  task automatic test_brightness();
    int lit [0:7];
    int stray;
    logic [31:0] lvl [0:1] = '{32'h3, 32'h0};
    int          want [0:1] = '{8, 2};
    for (int p = 0; p < 2; p++) begin
      bus_write(0, 4'd4, lvl[p]);
      repeat (4) @(negedge clk);
      count_period(lit, stray);
      for (int d = 0; d < 8; d++) begin
        checks++;
        if (lit[d] != want[p]) begin
          errors++;
          $display("FAIL bright_%0d digit %0d: lit %0d cycles, want %0d", lvl[p], d, lit[d], want[p]);
        end
      end
      checks++;
      if (stray != 0) begin
        errors++;
        $display("FAIL bright_ghost: %0d unlit cycles with seg/dp on, want 0", stray);
      end
    end
  endtask

  task automatic test_blink();
    int lit [0:7];
    int stray;
    // Counters run in lockstep from reset: digit 0's slot falls in blink
    // phase 0 (lit), digit 2's slot always in phase 1 (dark).
    bus_write(0, 4'd5, 32'h05);
    bus_write(0, 4'd4, 32'h0F);
    repeat (4) @(negedge clk);
    count_period(lit, stray);
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (lit[d] != ((d == 2) ? 0 : 16)) begin
        errors++;
        $display("FAIL blink digit %0d: lit %0d cycles, want %0d", d, lit[d], (d == 2) ? 0 : 16);
      end
    end
    bus_write(0, 4'd4, 32'h07);
    repeat (4) @(negedge clk);
    count_period(lit, stray);
    checks++;
    if (lit[2] != 16) begin
      errors++;
      $display("FAIL blink_off digit 2: lit %0d cycles, want 16", lit[2]);
    end
    bus_write(0, 4'd4, 32'h1F);
    repeat (4) @(negedge clk);
    count_period(lit, stray);
    checks++;
    if ((lit[0] + lit[1] + lit[2] + lit[3] + lit[4] + lit[5] + lit[6] + lit[7]) != 0 || stray != 0) begin
      errors++;
      $display("FAIL blank: lit digit0=%0d digit3=%0d stray=%0d, want all 0", lit[0], lit[3], stray);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int rdy_bad = 0;
    @(negedge clk);
    sel6 = 1'b1; trans = 2'b10; write = 1'b1; addr = 4'd3;
    @(negedge clk);
    if (rdy6 !== 1'b1) rdy_bad++;
    wdata = 32'hCAFEF00D; write = 1'b0; addr = 4'd3;
    @(negedge clk);
    if (rdy6 !== 1'b1) rdy_bad++;
    r = rdata6;
    checks++;
    if (r !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL b2b_read_diglo: got %h, want cafef00d", r);
    end
    addr = 4'd9;
    @(negedge clk);
    if (rdy6 !== 1'b1) rdy_bad++;
    r = rdata6;
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL b2b_read_unmapped: got %h, want 00000000", r);
    end
    addr = 4'd0;
    @(negedge clk);
    if (rdy6 !== 1'b1) rdy_bad++;
    r = rdata6;
    sel6 = 1'b0; trans = 2'b00;
    checks++;
    if (r !== 32'h3F) begin
      errors++;
      $display("FAIL b2b_read_en6: got %h, want 0000003f", r);
    end
    checks++;
    if (rdy_bad != 0) begin
      errors++;
      $display("FAIL hreadyout: low in %0d cycles, want 0", rdy_bad);
    end
  endtask

  task automatic test_reset_midwrite();
    logic [31:0] r;
    int n;
    bus_write(0, 4'd4, 32'h07);
    repeat (2) @(negedge clk);
    checks++;
    if (en8 === 8'hFF) begin
      errors++;
      $display("FAIL pre_reset_lit: en=%h, want one digit low", en8);
    end
    @(negedge clk);
    sel8 = 1'b1; trans = 2'b10; write = 1'b1; addr = 4'd3;
    @(negedge clk);
    sel8 = 1'b0; trans = 2'b00; write = 1'b0; wdata = 32'h12345678;
    rst_n = 1'b0;
    #1;
    checks++;
    if (en8 !== 8'hFF || seg8 !== 7'h7F || dp8 !== 1'b1 || rdata8 !== 32'h0 || en6 !== 6'h3F) begin
      errors++;
      $display("FAIL midreset_outputs: en8=%h seg=%h dp=%b rd=%h en6=%h, want ff 7f 1 0 3f",
               en8, seg8, dp8, rdata8, en6);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(0, 4'd3, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL midreset_diglo: got %h, want 00000000", r);
    end
    bus_write(0, 4'd0, 32'h0);
    n = 0;
    while (en8 === 8'hFF && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (en8 !== 8'hFE || seg8 !== 7'h40) begin
      errors++;
      $display("FAIL restart_digit0: en=%h seg=%h after %0d cycles, want en=fe seg=40", en8, seg8, n);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_brightness();
    test_blink();
    test_back_to_back();
    test_reset_midwrite();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
